branch_sequencer: RTL
=====================

# branch_sequencer

Hardwired control sequencer for the datapath. It generates the instruction-fetch strobes (T0–T2) and the full conditional-branch execute sequence (T3–T6), with a parametrised memory-read wait and an optional early exit on a not-taken branch. The datapath register-transfer, ALU and CON FF logic stay where they are; this block drives their control inputs. It replaces per-instruction hand sequencing in benches and forms the first piece of the control unit.

## Interface

Parameters:

- OPCODE_WIDTH, 5, width of the IR opcode field (IR[31:27]).
- BRANCH_OPCODE, 5'b10010, opcode value decoded as a conditional branch.
- ALU_ADD_CODE, 4'd2, CONTROL value that selects ADD in the ALU.
- MEM_WAIT, 1, number of cycles the T1 read state holds (1..15).
- SKIP_ON_FALSE, 0, when 1, a not-taken branch leaves after T4 and skips T5/T6.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports (reset is asynchronous and active-low):

- Clock, in, 1, sole clock; all state changes on the rising edge.
- Clear, in, 1, asynchronous active-low reset.
- run, in, 1, level; while high, the sequencer fetches and executes continuously.
- opcode, in, OPCODE_WIDTH, IR opcode field, valid from T3 on.
- con_ff, in, 1, CON FF output; reflects the CON_in evaluation from T4 on.
- PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CON_in, Yin, Cout, out, 1 each, datapath strobes.
- CONTROL, out, 4, ALU operation select.
- busy, out, 1, high in any state except IDLE.
- illegal, out, 1, one-cycle pulse when a non-branch opcode is decoded.
- retired, out, CNT_WIDTH, count of completed branch instructions.

## Operation

- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are a Moore decode of the state register. Every strobe not listed for a state is 0, and CONTROL is 0 outside T5.
- IDLE: no strobes. Go to T0 when run=1.
- T0: PCout, MARin, IncPC, Zlowin.
- T1: Zlowout, PCin, Read, MDRin. Internal wait counter loaded with MEM_WAIT-1 on entry. Stay in T1 until the counter reaches 0, with all strobes held for the whole stay. PCin stays asserted, which is harmless because Zlow is stable. Then go to T2.
- T2: MDRout, IRin.
- T3: decode opcode. If opcode==BRANCH_OPCODE, assert Gra, Rout, CON_in and go to T4. Otherwise assert no strobes, pulse illegal, and go to T0 if run=1, else IDLE.
- T4: PCout, Yin. If SKIP_ON_FALSE=1 and con_ff=0, retire and exit. Otherwise go to T5.
- T5: Cout, Zlowin, CONTROL=ALU_ADD_CODE.
- T6: Zlowout; PCin = con_ff, so PC is loaded only when the branch is taken. Retire and exit.
- Exit: next state is T0 if run=1, else IDLE. run is only sampled in IDLE and at exit points, so deasserting it mid-instruction lets the current instruction finish.
- Retire: retired increments by 1 on the exit edge and wraps from 2^CNT_WIDTH-1 to 0. An illegal opcode does not retire.
- Reset (Clear=0, any time, including mid-T1 wait): state goes to IDLE immediately, wait counter and retired go to 0, and all strobes, CONTROL, busy and illegal go to 0 without waiting for a clock edge.

## Timing

- One state per cycle, except that T1 lasts MEM_WAIT cycles.
- Fetch takes 2+MEM_WAIT cycles (T0, T1, T2).
- Full branch takes 6+MEM_WAIT cycles from T0 entry to T6 inclusive. With SKIP_ON_FALSE=1 and a not-taken branch, it takes 4+MEM_WAIT cycles.
- Illegal opcode: 3+MEM_WAIT cycles; illegal is high during the T3 cycle only.
- With run held high, back-to-back instructions have no idle cycle: the cycle after T6 is T0.
- con_ff must be stable from the first T4 edge through T6. The block does not latch it.
- busy rises the cycle after IDLE→T0 is taken and falls the cycle IDLE is re-entered.

## Test plan

- Taken branch, defaults (MEM_WAIT=1). Clear low then high, run=1, opcode=5'b10010 (IR 32'h91000023, brzr R2,35), con_ff=1 from T4. Required: strobes match the per-state lists above, CONTROL=2 only in cycle 6, PCin high in cycle 7 (T6), retired=1 after cycle 7, next state T0.
- Not-taken branch with SKIP_ON_FALSE=0 and con_ff=0. Required: T5 and T6 are still visited, PCin=0 in T6, retired increments. Repeat with SKIP_ON_FALSE=1: exit after T4, 5 cycles total, Cout never asserted.
- Illegal opcode 5'b00011. Required: illegal=1 for exactly one cycle (T3), Gra/Rout/CON_in stay 0, retired unchanged, next state T0.
- MEM_WAIT=3. Required: Read and MDRin high for exactly 3 consecutive cycles, branch total 9 cycles.
- Clear pulled low during the 2nd T1 cycle with MEM_WAIT=3. Required: all outputs 0 and busy=0 before the next edge. After release with run=1, the sequence restarts at T0 and retired=0.
- CNT_WIDTH=2, run held high for 5 taken branches. Required: retired goes 1,2,3,0,1, and there are no IDLE cycles between instructions.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Datapath control bundle between the branch sequencer and the register-transfer datapath.
// The sequencer drives the strobes and CONTROL; the datapath returns the opcode field and the CON FF.
interface branch_sequencer_if #(
  parameter int unsigned OPCODE_WIDTH = 5
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    con_ff;
  logic                    PCout;
  logic                    MARin;
  logic                    IncPC;
  logic                    Zlowin;
  logic                    Zlowout;
  logic                    PCin;
  logic                    Read;
  logic                    MDRin;
  logic                    MDRout;
  logic                    IRin;
  logic                    Gra;
  logic                    Rout;
  logic                    CON_in;
  logic                    Yin;
  logic                    Cout;
  logic [3:0]              CONTROL;

  modport master (
    input  opcode, con_ff,
    output PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rout, CON_in, Yin, Cout, CONTROL
  );

  modport slave (
    output opcode, con_ff,
    input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rout, CON_in, Yin, Cout, CONTROL
  );
endinterface

// File: rtl/branch_sequencer.sv
// Hardwired fetch + conditional-branch control sequencer.
// Walks IDLE/T0..T6, holds T1 for MEM_WAIT cycles and counts retired branches.
module branch_sequencer #(
  parameter int unsigned             OPCODE_WIDTH  = 5,
  parameter logic [OPCODE_WIDTH-1:0] BRANCH_OPCODE = OPCODE_WIDTH'(5'b10010),
  parameter logic [3:0]              ALU_ADD_CODE  = 4'd2,
  parameter int unsigned             MEM_WAIT      = 1,
  parameter bit                      SKIP_ON_FALSE = 1'b0,
  parameter int unsigned             CNT_WIDTH     = 16
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 run,
  branch_sequencer_if.master   bus,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_branch;
  logic              retire;

  assign is_branch = (bus.opcode == BRANCH_OPCODE);

  // State register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state; run is only looked at in IDLE and on instruction exit
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (wait_cnt == '0) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_branch) state_nxt = S_T4;
        else           state_nxt = run ? S_T0 : S_IDLE;
      end
      S_T4: begin
        if (SKIP_ON_FALSE && !bus.con_ff) begin
          retire    = 1'b1;
          state_nxt = run ? S_T0 : S_IDLE;
        end else begin
          state_nxt = S_T5;
        end
      end
      S_T5:   state_nxt = S_T6;
      S_T6: begin
        retire    = 1'b1;
        state_nxt = run ? S_T0 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory-read wait: loaded while in T0 so it is ready on T1 entry
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      wait_cnt <= '0;
    end else if (state == S_T0) begin
      wait_cnt <= WAIT_W'(MEM_WAIT - 1);
    end else if (state == S_T1 && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // Retired-branch counter, wraps naturally
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)      retired <= '0;
    else if (retire) retired <= retired + CNT_WIDTH'(1);
  end

  // Moore strobe decode; T3 qualifies on opcode and T6 PCin follows the CON FF
  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zlowin  = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CON_in  = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.CONTROL = 4'd0;
    busy        = (state != S_IDLE);
    illegal     = 1'b0;
    case (state)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.Gra    = is_branch;
        bus.Rout   = is_branch;
        bus.CON_in = is_branch;
        illegal    = !is_branch;
      end
      S_T4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
      end
      S_T5: begin
        bus.Cout    = 1'b1;
        bus.Zlowin  = 1'b1;
        bus.CONTROL = ALU_ADD_CODE;
      end
      S_T6: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = bus.con_ff;
      end
      default: ;
    endcase
  end

endmodule
